// File: rtl/dct_stream_checker.sv
// Joins an actual and an expected DCT coefficient stream and reports per-block error statistics.
// Optional squarer / SSE accumulator enabled by defining DCT_CHK_SSE_EN.
module dct_stream_checker #(
   parameter int DATA_WIDTH = 16,
   parameter int BLOCK_SIZE = 64,
   parameter int TOLERANCE  = 100,
   parameter int SSE_WIDTH  = 48,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              clear,
   input  logic                              s_act_tvalid,
   output logic                              s_act_tready,
   input  logic                              s_act_tlast,
   input  logic [DATA_WIDTH-1:0]             s_act_tdata,
   input  logic                              s_exp_tvalid,
   output logic                              s_exp_tready,
   input  logic                              s_exp_tlast,
   input  logic [DATA_WIDTH-1:0]             s_exp_tdata,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic                              res_pass,
   output logic [DATA_WIDTH:0]               res_max_err,
   output logic [$clog2(BLOCK_SIZE+1)-1:0]   res_mismatch_cnt,
   output logic [$clog2(BLOCK_SIZE)-1:0]     res_first_idx,
   output logic [SSE_WIDTH-1:0]              res_sse,
   output logic                              res_tlast_err,
   output logic [CNT_WIDTH-1:0]              blocks_total,
   output logic [CNT_WIDTH-1:0]              blocks_passed,
   output logic [CNT_WIDTH-1:0]              blocks_failed
);

   localparam int EW = DATA_WIDTH + 1;
   localparam int MW = $clog2(BLOCK_SIZE + 1);
   localparam int IW = $clog2(BLOCK_SIZE);

   typedef enum logic {S_RUN, S_REPORT} state_t;
   state_t state;

   logic [IW-1:0] beat_idx;
   logic [EW-1:0] max_acc;
   logic [MW-1:0] mm_acc;
   logic [IW-1:0] first_acc;
   logic          terr_acc;

   logic               fire;
   logic               last_beat;
   logic               res_hs;
   logic signed [EW-1:0] diff;
   logic [EW-1:0]      abs_v;
   logic               is_mm;
   logic [EW-1:0]      max_nxt;
   logic [MW-1:0]      mm_nxt;
   logic [IW-1:0]      first_nxt;
   logic               terr_nxt;

   // Join: each ready depends only on the opposite valid, never on its own.
   assign s_act_tready = (state == S_RUN) && s_exp_tvalid;
   assign s_exp_tready = (state == S_RUN) && s_act_tvalid;
   assign fire         = (state == S_RUN) && s_act_tvalid && s_exp_tvalid;
   assign last_beat    = (beat_idx == IW'(BLOCK_SIZE - 1));
   assign res_hs       = (state == S_REPORT) && res_ready;

   always_comb begin
      diff      = $signed({s_act_tdata[DATA_WIDTH-1], s_act_tdata})
                - $signed({s_exp_tdata[DATA_WIDTH-1], s_exp_tdata});
      abs_v     = diff[EW-1] ? EW'(-diff) : EW'(diff);
      is_mm     = (abs_v > EW'(TOLERANCE));
      max_nxt   = (abs_v > max_acc) ? abs_v : max_acc;
      mm_nxt    = mm_acc + MW'(is_mm);
      first_nxt = (is_mm && (mm_acc == '0)) ? beat_idx : first_acc;
      // Framing is judged on the beat count; tlast only flags errors.
      terr_nxt  = terr_acc | (last_beat ? !(s_act_tlast && s_exp_tlast)
                                        : (s_act_tlast || s_exp_tlast));
   end

`ifdef DCT_CHK_SSE_EN
   localparam int SQW  = 2 * EW;
   localparam int SUMW = ((SSE_WIDTH > SQW) ? SSE_WIDTH : SQW) + 1;

   logic [SQW-1:0]       sq;
   logic [SUMW-1:0]      sse_sum;
   logic [SSE_WIDTH-1:0] sse_nxt;
   logic [SSE_WIDTH-1:0] sse_acc;
   logic [SSE_WIDTH-1:0] res_sse_q;

   always_comb begin
      sq      = SQW'(abs_v) * SQW'(abs_v);
      sse_sum = SUMW'(sse_acc) + SUMW'(sq);
      sse_nxt = (sse_sum > SUMW'({SSE_WIDTH{1'b1}})) ? '1 : sse_sum[SSE_WIDTH-1:0];
   end

   // Accumulator register is the pipeline stage after the squarer; the last
   // beat's square is folded straight into the result so latency stays 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sse_acc   <= '0;
         res_sse_q <= '0;
      end else if (clear) begin
         sse_acc   <= '0;
         res_sse_q <= '0;
      end else if (fire) begin
         if (last_beat) res_sse_q <= sse_nxt;
         else           sse_acc   <= sse_nxt;
      end else if (res_hs) begin
         sse_acc <= '0;
      end
   end

   assign res_sse = res_sse_q;
`else
   assign res_sse = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_RUN;
         beat_idx         <= '0;
         max_acc          <= '0;
         mm_acc           <= '0;
         first_acc        <= '0;
         terr_acc         <= 1'b0;
         res_valid        <= 1'b0;
         res_pass         <= 1'b0;
         res_max_err      <= '0;
         res_mismatch_cnt <= '0;
         res_first_idx    <= '0;
         res_tlast_err    <= 1'b0;
         blocks_total     <= '0;
         blocks_passed    <= '0;
         blocks_failed    <= '0;
      end else if (clear) begin
         state            <= S_RUN;
         beat_idx         <= '0;
         max_acc          <= '0;
         mm_acc           <= '0;
         first_acc        <= '0;
         terr_acc         <= 1'b0;
         res_valid        <= 1'b0;
         res_pass         <= 1'b0;
         res_max_err      <= '0;
         res_mismatch_cnt <= '0;
         res_first_idx    <= '0;
         res_tlast_err    <= 1'b0;
         blocks_total     <= '0;
         blocks_passed    <= '0;
         blocks_failed    <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (fire) begin
                  if (last_beat) begin
                     beat_idx         <= '0;
                     res_max_err      <= max_nxt;
                     res_mismatch_cnt <= mm_nxt;
                     res_first_idx    <= first_nxt;
                     res_tlast_err    <= terr_nxt;
                     res_pass         <= (mm_nxt == '0) && !terr_nxt;
                     res_valid        <= 1'b1;
                     state            <= S_REPORT;
                  end else begin
                     beat_idx  <= beat_idx + IW'(1);
                     max_acc   <= max_nxt;
                     mm_acc    <= mm_nxt;
                     first_acc <= first_nxt;
                     terr_acc  <= terr_nxt;
                  end
               end
            end
            S_REPORT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  max_acc   <= '0;
                  mm_acc    <= '0;
                  first_acc <= '0;
                  terr_acc  <= 1'b0;
                  if (blocks_total != '1) blocks_total <= blocks_total + CNT_WIDTH'(1);
                  if (res_pass) begin
                     if (blocks_passed != '1) blocks_passed <= blocks_passed + CNT_WIDTH'(1);
                  end else begin
                     if (blocks_failed != '1) blocks_failed <= blocks_failed + CNT_WIDTH'(1);
                  end
                  state <= S_RUN;
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_dct_stream_checker.sv
// Randomised directed bench for dct_stream_checker against a block-level reference model.
module tb_dct_stream_checker;

   localparam int N = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        s_act_tvalid = 1'b0, s_act_tlast = 1'b0;
   logic        s_exp_tvalid = 1'b0, s_exp_tlast = 1'b0;
   logic [15:0] s_act_tdata = '0, s_exp_tdata = '0;
   logic        s_act_tready, s_exp_tready;
   logic        res_valid, res_pass, res_tlast_err;
   logic        res_ready = 1'b0;
   logic [16:0] res_max_err;
   logic [6:0]  res_mismatch_cnt;
   logic [5:0]  res_first_idx;
   logic [47:0] res_sse;
   logic [15:0] blocks_total, blocks_passed, blocks_failed;

   dct_stream_checker #(.DATA_WIDTH(16), .BLOCK_SIZE(N), .TOLERANCE(100),
                        .SSE_WIDTH(48), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .s_act_tvalid(s_act_tvalid), .s_act_tready(s_act_tready),
      .s_act_tlast(s_act_tlast), .s_act_tdata(s_act_tdata),
      .s_exp_tvalid(s_exp_tvalid), .s_exp_tready(s_exp_tready),
      .s_exp_tlast(s_exp_tlast), .s_exp_tdata(s_exp_tdata),
      .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass),
      .res_max_err(res_max_err), .res_mismatch_cnt(res_mismatch_cnt),
      .res_first_idx(res_first_idx), .res_sse(res_sse),
      .res_tlast_err(res_tlast_err), .blocks_total(blocks_total),
      .blocks_passed(blocks_passed), .blocks_failed(blocks_failed));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic signed [15:0] act_a [N];
   logic signed [15:0] exp_a [N];
   logic               alast [N];
   logic               elast [N];

   // reference results
   logic              m_pass, m_terr;
   int                m_max, m_mm, m_first;
   longint unsigned   m_sse;
   int                t_total = 0, t_pass = 0, t_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model();
      int d, a;
      m_max = 0; m_mm = 0; m_first = 0; m_sse = 0; m_terr = 1'b0;
      for (int k = 0; k < N; k++) begin
         d = int'(act_a[k]) - int'(exp_a[k]);
         a = (d < 0) ? -d : d;
         if (a > m_max) m_max = a;
         if (a > 100) begin
            if (m_mm == 0) m_first = k;
            m_mm++;
         end
         m_sse += longint'(a) * longint'(a);
         if (k == N-1) begin
            if (!(alast[k] && elast[k])) m_terr = 1'b1;
         end else if (alast[k] || elast[k]) m_terr = 1'b1;
      end
      if (m_sse > 64'h0000_FFFF_FFFF_FFFF) m_sse = 64'h0000_FFFF_FFFF_FFFF;
`ifndef DCT_CHK_SSE_EN
      m_sse = 0;
`endif
      m_pass = (m_mm == 0) && !m_terr;
   endtask

   task automatic fill_equal();
      for (int k = 0; k < N; k++) begin
         exp_a[k] = 16'($urandom);
         act_a[k] = exp_a[k];
         alast[k] = (k == N-1);
         elast[k] = (k == N-1);
      end
   endtask

   task automatic fill_random();
      int v;
      for (int k = 0; k < N; k++) begin
         exp_a[k] = 16'($urandom);
         case ($urandom_range(3))
            0: act_a[k] = exp_a[k];
            1: act_a[k] = exp_a[k] + 16'($urandom_range(200)) - 16'd100;
            2: act_a[k] = exp_a[k] + 16'($urandom_range(600)) - 16'd300;
            default: act_a[k] = 16'($urandom);
         endcase
         alast[k] = (k == N-1);
         elast[k] = (k == N-1);
      end
      if ($urandom_range(4) == 0) begin
         v = $urandom_range(N-1);
         if ($urandom_range(1) == 0) alast[v] = ~alast[v];
         else                        elast[v] = ~elast[v];
      end
   endtask

   // Drive beats with independent random valid gaps until n beats have joined.
   task automatic run_beats(input int n, input int gap);
      int i, cyc;
      logic av, ev, f;
      i = 0; cyc = 0;
      while (i < n && cyc < 4000) begin
         @(negedge clk);
         av = ($urandom_range(99) >= gap);
         ev = ($urandom_range(99) >= gap);
         s_act_tvalid = av; s_act_tdata = act_a[i]; s_act_tlast = alast[i];
         s_exp_tvalid = ev; s_exp_tdata = exp_a[i]; s_exp_tlast = elast[i];
         #1;
         if (cyc == 3) begin
            check("act_tready_join", s_act_tready, ev);
            check("exp_tready_join", s_exp_tready, av);
         end
         f = av && ev && s_act_tready && s_exp_tready;
         @(posedge clk);
         if (f) i++;
         cyc++;
      end
      @(negedge clk);
      s_act_tvalid = 1'b0; s_exp_tvalid = 1'b0;
      s_act_tlast = 1'b0; s_exp_tlast = 1'b0;
      check("beats_accepted", i, n);
   endtask

   task automatic check_result(input string tag);
      model();
      #1;
      check({tag, ".res_valid"}, res_valid, 1'b1);
      check({tag, ".pass"}, res_pass, m_pass);
      check({tag, ".max_err"}, res_max_err, m_max);
      check({tag, ".mismatch_cnt"}, res_mismatch_cnt, m_mm);
      check({tag, ".first_idx"}, res_first_idx, m_first);
      check({tag, ".sse"}, res_sse, m_sse);
      check({tag, ".tlast_err"}, res_tlast_err, m_terr);
   endtask

   task automatic handshake(input string tag, input int hold);
      logic [16:0] me;
      logic [47:0] se;
      me = res_max_err; se = res_sse;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         s_act_tvalid = 1'b1; s_exp_tvalid = 1'b1; res_ready = 1'b0;
         #1;
         check({tag, ".hold_treadys"}, {s_act_tready, s_exp_tready}, 2'b00);
         check({tag, ".hold_stable"}, {res_valid, res_max_err, res_sse}, {1'b1, me, se});
         check({tag, ".hold_totals"}, blocks_total, t_total);
      end
      @(negedge clk);
      s_act_tvalid = 1'b0; s_exp_tvalid = 1'b0; res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      t_total++;
      if (m_pass) t_pass++; else t_fail++;
      #1;
      check({tag, ".res_valid_drop"}, res_valid, 1'b0);
      check({tag, ".totals"}, {blocks_total, blocks_passed, blocks_failed},
            {16'(t_total), 16'(t_pass), 16'(t_fail)});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".outs"}, {s_act_tready, s_exp_tready, res_valid, res_pass,
            res_max_err, res_mismatch_cnt, res_first_idx, res_tlast_err}, '0);
      check({tag, ".sse"}, res_sse, 0);
      check({tag, ".totals"}, {blocks_total, blocks_passed, blocks_failed}, '0);
   endtask

   initial begin
      // reset state
      #12;
      check_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;

      // identical block
      fill_equal();
      run_beats(N, 30);
      check_result("equal");
      handshake("equal", 0);

      // single +101 error at beat 5
      fill_equal();
      for (int k = 0; k < N; k++) exp_a[k] = 16'($urandom_range(2000)) - 16'sd1000;
      for (int k = 0; k < N; k++) act_a[k] = exp_a[k];
      act_a[5] = exp_a[5] + 16'sd101;
      run_beats(N, 20);
      check_result("plus101");
      handshake("plus101", 0);

      // -100 at every beat stays within tolerance
      for (int k = 0; k < N; k++) begin
         exp_a[k] = 16'($urandom_range(60000)) - 16'sd30000;
         act_a[k] = exp_a[k] - 16'sd100;
      end
      run_beats(N, 0);
      check_result("minus100");
      handshake("minus100", 0);

      // extreme difference, no wrap
      fill_equal();
      act_a[17] = 16'sh8000; exp_a[17] = 16'sh7FFF;
      run_beats(N, 10);
      check_result("extreme");
      handshake("extreme", 0);

      // early act tlast
      fill_equal();
      alast[62] = 1'b1;
      run_beats(N, 10);
      check_result("early_tlast");
      handshake("early_tlast", 0);

      // backpressure on the result
      fill_random();
      run_beats(N, 25);
      check_result("backpressure");
      handshake("backpressure", 5);

      // randomised blocks
      for (int b = 0; b < 6; b++) begin
         fill_random();
         run_beats(N, 40);
         check_result("random");
         handshake("random", $urandom_range(2));
      end

      // clear while a result is pending drops it uncounted
      fill_random();
      run_beats(N, 10);
      check_result("pre_clear");
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      t_total = 0; t_pass = 0; t_fail = 0;
      #1;
      check_all_zero("clear");

      // asynchronous reset mid-block
      fill_equal();
      act_a[3] = exp_a[3] + 16'sd500;
      run_beats(30, 10);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk); rst_n = 1'b1;
      t_total = 0; t_pass = 0; t_fail = 0;
      fill_equal();
      act_a[2] = exp_a[2] - 16'sd300;
      run_beats(N, 10);
      check_result("after_reset");
      handshake("after_reset", 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dct_stream_checker.md
# dct_stream_checker

Synthesizable self-checking comparator for DCT coefficient streams. Joins a DUT output AXI-Stream with an expected-coefficient AXI-Stream, then computes per-block error statistics: maximum absolute error, tolerance mismatches, sum of squared error, first mismatch index and framing errors. It also keeps running pass/fail totals. It sits beside `dct2d_top` in on-chip regression and FPGA bring-up, and generalises the bench-side golden comparison to any block size, width and tolerance.

## Interface
- `DATA_WIDTH`, 16, coefficient width (signed two's complement)
- `BLOCK_SIZE`, 64, beats per block (≥2)
- `TOLERANCE`, 100, largest absolute error still counted as a match
- `SSE_WIDTH`, 48, sum-of-squared-error accumulator width
- `CNT_WIDTH`, 16, block counter width

- `clk` in 1: clock
- `rst_n` in 1: asynchronous, active-low reset
- `clear` in 1: synchronous flush of accumulators and counters
- `s_act_tvalid`/`s_act_tready`/`s_act_tlast` in/out/in 1: actual stream handshake and framing
- `s_act_tdata` in DATA_WIDTH: actual coefficient
- `s_exp_tvalid`/`s_exp_tready`/`s_exp_tlast` in/out/in 1: expected stream handshake and framing
- `s_exp_tdata` in DATA_WIDTH: expected coefficient
- `res_valid` out 1: block result available
- `res_ready` in 1: result consumed
- `res_pass` out 1: block passed
- `res_max_err` out DATA_WIDTH+1: maximum absolute error in the block
- `res_mismatch_cnt` out clog2(BLOCK_SIZE+1): number of beats with error > TOLERANCE
- `res_first_idx` out clog2(BLOCK_SIZE): beat index of the first mismatch; 0 if none
- `res_sse` out SSE_WIDTH: sum of squared errors
- `res_tlast_err` out 1: framing error seen in the block
- `blocks_total`/`blocks_passed`/`blocks_failed` out CNT_WIDTH each: running totals

## Operation
- States: RUN (accepting beats) and REPORT (holding a result). Reset and `clear` enter RUN.
- Join rules:
  - `s_act_tready = RUN && s_exp_tvalid`
  - `s_exp_tready = RUN && s_act_tvalid`
  - A beat is consumed only when both streams fire in the same cycle. No ready depends on its own valid.
- Per beat:
  - `diff` = sign-extended act − exp, computed in DATA_WIDTH+1 bits.
  - `abs` = |diff|, unsigned DATA_WIDTH+1 bits. Maximum is 2^DATA_WIDTH−1, so there is no overflow.
  - If abs > max_err, update max_err.
  - If abs > TOLERANCE, increment the mismatch counter. On the first mismatch of the block, latch the beat index.
  - sse += abs², saturating at all-ones.
- Framing is count-based: the beat counter runs 0..BLOCK_SIZE−1.
  - On either stream, tlast at beat ≠ BLOCK_SIZE−1 sets tlast_err.
  - Missing tlast at beat BLOCK_SIZE−1 also sets tlast_err.
  - The block still closes at count BLOCK_SIZE−1.
- Block end: register results, enter REPORT, assert `res_valid`.
  - `res_pass = (mismatch_cnt == 0) && !tlast_err`.
- REPORT:
  - Both treadys are 0, so both input streams stall.
  - Result outputs stay stable until `res_valid && res_ready`.
  - On that handshake: update totals, clear the per-block accumulators, return to RUN.
- Totals increment only on the result handshake and saturate at all-ones.
- `clear` has highest priority: zeroes everything and drops `res_valid` even mid-REPORT. A result dropped this way is not counted.

## Timing
- Reset values: every output 0, including both treadys and `res_valid`. State is RUN.
- Latency: `res_valid` rises the cycle after the final beat handshake.
- Earliest next beat is the cycle after the result handshake. Minimum per-block period is BLOCK_SIZE+1 cycles with `res_ready` tied high.
- The result registers update only on entry to REPORT.
- Totals update on the edge that completes the result handshake.
- Reset mid-block discards partial statistics immediately (asynchronous); the next block restarts at index 0.
- A single registered pipeline stage follows the multiplier, and the last-beat SSE is included before `res_valid`. This keeps the 1-cycle result latency.

## Configuration
- `DCT_CHK_SSE_EN` defined: squarer and SSE accumulator present; `res_sse` valid.
- `DCT_CHK_SSE_EN` undefined: squarer removed; `res_sse` is tied to 0. All other behaviour is unchanged.

## Test plan
- 64 identical beats, both tlast on beat 63 → `res_pass`=1, max_err=0, mismatch_cnt=0, sse=0; totals 1/1/0.
- act = exp + 101 at beat 5 only → pass=0, mismatch_cnt=1, first_idx=5, max_err=101, sse=10201; blocks_failed=1.
- act = exp − 100 at every beat → pass=1, max_err=100, sse=640000 (with SSE_EN).
- act −32768 vs exp 32767 on one beat → max_err=65535 and sse=4294836225, with no wrap.
- act tlast on beat 62 → tlast_err=1, pass=0; the block still closes after beat 63.
- Backpressure and reset:
  - `res_ready` held low for 5 cycles → both treadys stay 0 and results stay stable; totals update only on the handshake.
  - `rst_n` low at beat 30 → all outputs 0; the next block is judged from a fresh index 0.
